// File: rtl/multicycle_mips.sv
// rtl/multicycle_mips.sv - multicycle MIPS-subset core on one shared memory port
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_mips #(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter int          NREGS    = 32,
  parameter int          MEM_AW   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_out
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'h05;
`endif

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
  // Register $0 is not stored at all; it reads as zero by construction.
  logic [31:0] rf_q [1:NREGS-1];
  logic [31:0] rf_d [1:NREGS-1];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rs_val, rt_val, r_result, wr_data;
  logic        r_ok, op_legal, wr_en;
  logic [4:0]  wr_idx;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // Indices at or above NREGS fall through the loop and read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs == 5'(i)) rs_val = rf_q[i];
      if (rt == 5'(i)) rt_val = rf_q[i];
    end
  end

  always_comb begin
    case (op)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
`ifdef MULTICYCLE_BNE_EN
      OP_BNE: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    r_result = '0;
    r_ok     = 1'b1;
    case (funct)
      6'h20:   r_result = a_q + b_q;
      6'h22:   r_result = a_q - b_q;
      6'h24:   r_result = a_q & b_q;
      6'h25:   r_result = a_q | b_q;
      6'h2A:   r_result = {31'b0, $signed(a_q) < $signed(b_q)};
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_d    = rf_q;
    wr_en   = 1'b0;
    wr_idx  = rt;
    wr_data = alu_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        alu_d = pc_q + {imm_sext[29:0], 2'b00};
        if (op == OP_J) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          state_d = S_FETCH;
        end else if (!op_legal) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_R: begin
            alu_d   = r_result;
            state_d = r_ok ? S_WB : S_HALT;
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_sext;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sext;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = alu_q;
            state_d = S_FETCH;
          end
`ifdef MULTICYCLE_BNE_EN
          OP_BNE: begin
            if (a_q != b_q) pc_d = alu_q;
            state_d = S_FETCH;
          end
`endif
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        wr_en   = 1'b1;
        wr_idx  = (op == OP_R) ? rd : rt;
        wr_data = (op == OP_LW) ? mdr_q : alu_q;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    for (int i = 1; i < NREGS; i++) begin
      if (wr_en && wr_idx == 5'(i)) rf_d[i] = wr_data;
    end
  end

  // Bus outputs decode from state and registers only, never from mem_ready.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {pc_q[MEM_AW-1:2], 2'b00};
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_SW);
        mem_addr  = {alu_q[MEM_AW-1:2], 2'b00};
        mem_wdata = (op == OP_SW) ? b_q : '0;
      end
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign pc_out = pc_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_BOOT;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 1; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_multicycle_mips.sv
// tb/tb_multicycle_mips.sv - self-checking bench for multicycle_mips
// An instruction-level model predicts every bus transaction and its cycle.
module tb_multicycle_mips;

  localparam logic [31:0] PC_RST = 32'h40;
  localparam int          AW     = 16;
  localparam int          NR     = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          mem_req, mem_we, mem_ready, halted;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, pc_out;

  multicycle_mips #(.PC_RESET(PC_RST), .NREGS(NR), .MEM_AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .pc_out(pc_out)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory with a programmable number of wait cycles per access.
  logic [31:0] init_mem [1024];
  logic [31:0] mem [1024];
  int wait_states = 0;
  int wait_cnt;
  int cyc;

  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = (wait_cnt == wait_states);

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= 0;
      cyc      <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_mem[i];
    end else begin
      cyc <= cyc + 1;
      if (mem_req) begin
        if (wait_cnt == wait_states) begin
          wait_cnt <= 0;
          if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  typedef struct {
    int          cyc;
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } acc_t;

  acc_t        expq[$];
  int          start_cyc[$];
  bit          exp_halt;
  int          exp_halt_cyc;
  logic [31:0] exp_halt_pc;

  function automatic acc_t mk(input int c, input bit f, input bit we,
                              input logic [31:0] ad, input logic [31:0] d, input logic [31:0] p);
    acc_t e;
    e.cyc = c; e.fetch = f; e.we = we; e.addr = ad; e.data = d; e.pc = p;
    return e;
  endfunction

  // Runs the program architecturally; instruction costs come from the CPI table plus W per access.
  task automatic build_expect(input int max_instr);
    logic [31:0] mm [1024];
    logic [31:0] rg [32];
    logic [31:0] pc, ir, a, b, imm, npc, ea, res;
    int s, w, op, fn, rsi, rti, rdi;
    bit ok;
    mm = init_mem;
    for (int i = 0; i < 32; i++) rg[i] = 0;
    pc = PC_RST; s = 1; w = wait_states;
    expq.delete(); start_cyc.delete();
    exp_halt = 0; exp_halt_cyc = 0; exp_halt_pc = 0;
    for (int n = 0; n < max_instr && !exp_halt; n++) begin
      start_cyc.push_back(s);
      ir = mm[pc[11:2]];
      expq.push_back(mk(s + w, 1, 0, pc & 32'hFFFF, 0, pc));
      op = int'(ir[31:26]); fn = int'(ir[5:0]);
      rsi = int'(ir[25:21]); rti = int'(ir[20:16]); rdi = int'(ir[15:11]);
      a = (rsi < NR) ? rg[rsi] : 32'h0;
      b = (rti < NR) ? rg[rti] : 32'h0;
      imm = {{16{ir[15]}}, ir[15:0]};
      npc = pc + 4;
      case (op)
        0: begin
          ok = 1; res = 0;
          case (fn)
            32: res = a + b;
            34: res = a - b;
            36: res = a & b;
            37: res = a | b;
            42: res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: ok = 0;
          endcase
          if (ok) begin
            if (rdi != 0 && rdi < NR) rg[rdi] = res;
            s += w + 4;
          end else begin
            exp_halt = 1; exp_halt_cyc = s + w + 3;
          end
        end
        8: begin
          if (rti != 0 && rti < NR) rg[rti] = a + imm;
          s += w + 4;
        end
        35: begin
          ea = a + imm;
          expq.push_back(mk(s + 2*w + 3, 0, 0, ea & 32'hFFFC, 0, 0));
          if (rti != 0 && rti < NR) rg[rti] = mm[ea[11:2]];
          s += 2*w + 5;
        end
        43: begin
          ea = a + imm;
          expq.push_back(mk(s + 2*w + 3, 0, 1, ea & 32'hFFFC, b, 0));
          mm[ea[11:2]] = b;
          s += 2*w + 4;
        end
        4: begin
          if (a == b) npc = npc + (imm << 2);
          s += w + 3;
        end
`ifdef MULTICYCLE_BNE_EN
        5: begin
          if (a != b) npc = npc + (imm << 2);
          s += w + 3;
        end
`endif
        2: begin
          npc = {npc[31:28], ir[25:0], 2'b00};
          s += w + 2;
        end
        default: begin
          exp_halt = 1; exp_halt_cyc = s + w + 2;
        end
      endcase
      if (exp_halt) exp_halt_pc = npc;
      pc = npc;
    end
  endtask

  bit   active = 0;
  acc_t cmp_e;

  always @(negedge CLK) begin
    if (active) begin
      if (mem_req === 1'b1) begin
        if (mem_ready) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_access actual_addr=%h required=none", mem_addr);
          end else begin
            cmp_e = expq.pop_front();
            chk("acc_cycle", cyc, cmp_e.cyc);
            chk("acc_addr", {16'h0, mem_addr}, cmp_e.addr);
            chk("acc_we", {31'h0, mem_we}, {31'h0, cmp_e.we});
            if (cmp_e.we) chk("store_data", mem_wdata, cmp_e.data);
            if (cmp_e.fetch) chk("fetch_pc", pc_out, cmp_e.pc);
          end
        end
      end else begin
        chk("idle_addr", {16'h0, mem_addr}, 0);
        chk("idle_we", {31'h0, mem_we}, 0);
        chk("idle_wdata", mem_wdata, 0);
      end
      chk("halted", {31'h0, halted}, {31'h0, exp_halt && (cyc >= exp_halt_cyc)});
    end
  end

  task automatic put(input logic [31:0] addr, input logic [31:0] data);
    init_mem[addr[11:2]] = data;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) init_mem[i] = 0;
  endtask

  task automatic run_prog(input int w, input int max_instr);
    bit to;
    wait_states = w;
    build_expect(max_instr);
    @(negedge CLK); RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", {31'h0, mem_req}, 0);
    chk("rst_we", {31'h0, mem_we}, 0);
    chk("rst_addr", {16'h0, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_halted", {31'h0, halted}, 0);
    chk("rst_pc", pc_out, 32'h40);
    @(negedge CLK); RST_N = 1'b1; active = 1;
    @(posedge CLK); #1;
    chk("first_req", {31'h0, mem_req}, 1);
    chk("first_addr", {16'h0, mem_addr}, 32'h40);
    to = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK);
      if (exp_halt ? (cyc >= exp_halt_cyc + 4) : (expq.size() == 0)) begin
        to = 0;
        break;
      end
    end
    active = 0;
    chk("timeout", {31'h0, to}, 0);
    if (exp_halt) begin
      #1;
      chk("end_halted", {31'h0, halted}, 1);
      chk("end_req", {31'h0, mem_req}, 0);
      chk("end_pc", pc_out, exp_halt_pc);
      chk("pending", expq.size(), 0);
    end
  endtask

  bit found;

  initial begin
    // ALU, writeback, $0 protection, NREGS=8 and bne, zero wait states
    clear_mem();
    put(32'h40, 32'h20010005);  // addi $1,$0,5
    put(32'h44, 32'h2002FFFD);  // addi $2,$0,-3
    put(32'h48, 32'h00221820);  // add  $3,$1,$2
    put(32'h4C, 32'h00412022);  // sub  $4,$2,$1
    put(32'h50, 32'h0041282A);  // slt  $5,$2,$1
    put(32'h54, 32'h00223024);  // and  $6,$1,$2
    put(32'h58, 32'h00223825);  // or   $7,$1,$2
    put(32'h5C, 32'hAC030200);
    put(32'h60, 32'hAC040204);
    put(32'h64, 32'hAC050208);
    put(32'h68, 32'hAC06020C);
    put(32'h6C, 32'hAC070210);
    put(32'h70, 32'h20000009);  // addi $0,$0,9
    put(32'h74, 32'hAC000214);
    put(32'h78, 32'h20090007);  // addi $9,$0,7
    put(32'h7C, 32'h01200820);  // add  $1,$9,$0
    put(32'h80, 32'h14200001);  // bne  $1,$0,+1
    put(32'h84, 32'hAC010218);
    put(32'h88, 32'hFC000000);
    put(32'h214, 32'hDEADBEEF);
    put(32'h218, 32'hDEADBEEF);
    run_prog(0, 100);
    chk("pin_first_fetch", expq.size() == 0 ? start_cyc[0] : -1, 1);
    chk("pin_alu_20cyc", start_cyc[5] - start_cyc[0], 20);
    chk("mem_add", mem[128], 32'h2);
    chk("mem_sub", mem[129], 32'hFFFFFFF8);
    chk("mem_slt", mem[130], 32'h1);
    chk("mem_and", mem[131], 32'h5);
    chk("mem_or", mem[132], 32'hFFFFFFFD);
    chk("mem_r0", mem[133], 32'h0);
`ifdef MULTICYCLE_BNE_EN
    chk("mem_nreg", mem[134], 32'h0);
    chk("pin_halt_pc", exp_halt_pc, 32'h8C);
`else
    chk("mem_nreg", mem[134], 32'hDEADBEEF);
    chk("pin_halt_pc", exp_halt_pc, 32'h84);
`endif

    // Store then load with two wait cycles per access, illegal funct halts
    clear_mem();
    put(32'h40, 32'h20010005);  // addi $1,$0,5
    put(32'h44, 32'hAC010008);  // sw   $1,8($0)
    put(32'h48, 32'h8C060008);  // lw   $6,8($0)
    put(32'h4C, 32'hAC060220);  // sw   $6,0x220($0)
    put(32'h50, 32'h0000003F);
    run_prog(2, 100);
    chk("pin_ldst_cycles", start_cyc[3] - start_cyc[1], 17);
    chk("pin_halt_pc2", exp_halt_pc, 32'h54);
    chk("mem_sw", mem[2], 32'h5);
    chk("mem_lw", mem[136], 32'h5);

    // Jump, taken/not-taken beq and a self-loop, one wait cycle
    clear_mem();
    put(32'h40, 32'h08000100);  // j 0x100
    put(32'h400, 32'h10000001); // beq $0,$0,+1
    put(32'h404, 32'hFC000000);
    put(32'h408, 32'h20020001); // addi $2,$0,1
    put(32'h40C, 32'h10400005); // beq $2,$0,+5
    put(32'h410, 32'h1000FFFF); // beq $0,$0,-1
    run_prog(1, 7);
    chk("pin_no_halt", {31'h0, exp_halt}, 0);
    chk("pin_j_count", start_cyc.size(), 7);
    chk("pin_loop_cyc", start_cyc[6] - start_cyc[5], 4);

    // Reset asserted during a stalled store
    clear_mem();
    put(32'h40, 32'h20010005);
    put(32'h44, 32'hAC010008);
    put(32'h48, 32'hFC000000);
    wait_states = 4;
    @(negedge CLK); RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (mem_req && mem_we) begin
        found = 1;
        break;
      end
    end
    chk("stall_store_seen", {31'h0, found}, 1);
    chk("stall_store_addr", {16'h0, mem_addr}, 32'h8);
    chk("stall_store_data", mem_wdata, 32'h5);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, mem_req}, 0);
    chk("rst_mid_we", {31'h0, mem_we}, 0);
    chk("rst_mid_pc", pc_out, 32'h40);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("restart_req", {31'h0, mem_req}, 1);
    chk("restart_addr", {16'h0, mem_addr}, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
